r_mem_ctrl: RTL and testbench

Sequencer for the 13-bit × 2048 distributed coefficient memory used by the SNTRUP757 datapath. It owns the memory's write and read ports and runs one of three jobs at a time: zero-fill (CLEAR), streaming write (LOAD) and streaming read (READ). Each job covers P consecutive addresses from a latched base address. Upstream producers and downstream multiplier stages reach the memory only through this block's valid/ready streams.

---
 rtl/r_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_r_mem_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_mem_ctrl.sv
// Job sequencer for the 13-bit x 2048 coefficient memory: CLEAR, LOAD and READ over P addresses from base.
// Define R_MEM_CTRL_CLEAR_EN to build the zero-fill (CLEAR) job; otherwise start_clear is ignored.
module r_mem_ctrl #(
    parameter int unsigned RAM_WIDTH     = 13,
    parameter int unsigned RAM_ADDR_BITS = 11,
    parameter int unsigned P             = 757
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_clear,
    input  logic                     start_load,
    input  logic                     start_read,
    input  logic [RAM_ADDR_BITS-1:0] base,
    output logic                     busy,
    output logic                     done,
    input  logic [RAM_WIDTH-1:0]     in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     mem_we,
    output logic [RAM_ADDR_BITS-1:0] mem_waddr,
    output logic [RAM_WIDTH-1:0]     mem_wdata,
    output logic [RAM_ADDR_BITS-1:0] mem_raddr,
    input  logic [RAM_WIDTH-1:0]     mem_rdata
);

    localparam int unsigned CNT_W = $clog2(P + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(P);

    localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef R_MEM_CTRL_CLEAR_EN
    localparam logic [1:0] S_CLEAR = 2'd1;
`endif
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [RAM_ADDR_BITS-1:0] base_q, base_d;
    logic                     done_q, done_d;
    logic                     out_valid_q, out_valid_d;
    logic [RAM_WIDTH-1:0]     out_data_q, out_data_d;
    logic [RAM_ADDR_BITS-1:0] addr;
    logic                     start_any;

`ifndef R_MEM_CTRL_CLEAR_EN
    logic unused_start_clear;
    assign unused_start_clear = start_clear;
`endif

    // Job address wraps modulo the memory depth.
    assign addr      = base_q + RAM_ADDR_BITS'(cnt_q);
    assign mem_raddr = addr;

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef R_MEM_CTRL_CLEAR_EN
    assign start_any = start_clear | start_load | start_read;
`else
    assign start_any = start_load | start_read;
`endif

    // Next-state, counter and memory-port control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;

        case (state_q)
            S_IDLE: begin
                out_valid_d = 1'b0;
                // Later assignments win, giving clear > load > read.
                if (start_read) begin
                    state_d = S_READ;
                end
                if (start_load) begin
                    state_d = S_LOAD;
                end
`ifdef R_MEM_CTRL_CLEAR_EN
                if (start_clear) begin
                    state_d = S_CLEAR;
                end
`endif
                if (start_any) begin
                    base_d = base;
                    cnt_d  = '0;
                end
            end

`ifdef R_MEM_CTRL_CLEAR_EN
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = addr;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif

            S_LOAD: begin
                in_ready  = 1'b1;
                mem_waddr = addr;
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = in_data;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_READ: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (cnt_q == CNT_FULL) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                // Refill the output register whenever it is empty or being drained.
                if ((!out_valid_q || out_ready) && (cnt_q < CNT_FULL)) begin
                    out_data_d  = mem_rdata;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_r_mem_ctrl.sv
// Self-checking bench for r_mem_ctrl: start-priority vector table plus scoreboarded CLEAR/LOAD/READ jobs.
module tb_r_mem_ctrl;

    localparam int unsigned RW = 13;
    localparam int unsigned AW = 11;
    localparam int unsigned PP = 757;

`ifdef R_MEM_CTRL_CLEAR_EN
    localparam logic CLR = 1'b1;
`else
    localparam logic CLR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start_clear, start_load, start_read;
    logic [AW-1:0] base;
    logic          busy, done;
    logic [RW-1:0] in_data;
    logic          in_valid, in_ready;
    logic [RW-1:0] out_data;
    logic          out_valid, out_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [RW-1:0] mem_wdata, mem_rdata;

    logic [RW-1:0] mem [0:2047];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } wr_t;

    typedef struct {
        logic sc;
        logic sl;
        logic sr;
        logic e_busy;
        logic e_ir;
        logic e_we;
    } vec_t;

    wr_t           wq[$];
    logic [RW-1:0] rq[$];
    int            checks   = 0;
    int            failures = 0;
    int            rd_hs    = 0;
    int            done_cnt = 0;

    r_mem_ctrl #(.RAM_WIDTH(RW), .RAM_ADDR_BITS(AW), .P(PP)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_clear(start_clear),
        .start_load (start_load),
        .start_read (start_read),
        .base       (base),
        .busy       (busy),
        .done       (done),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic exp_wr(input int a, input int d);
        wr_t w;
        w.addr = AW'(a);
        w.data = RW'(d);
        wq.push_back(w);
    endtask

    // Sample on the falling edge; drain write and read scoreboards.
    task automatic sample();
        wr_t           w;
        logic [RW-1:0] r;
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %0d, want no write", mem_waddr, mem_wdata);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(mem_waddr), 32'(w.addr));
                chk("wr_data", 32'(mem_wdata), 32'(w.data));
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            rd_hs++;
            if (rq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got data %0d, want no output", out_data);
            end else begin
                r = rq.pop_front();
                chk("rd_data", 32'(out_data), 32'(r));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vt[8];
        int   beat, cyc, bad, gap, hs0, dc0;

        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, CLR,  1'b0,  CLR};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1,  1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, !CLR,  CLR};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, !CLR,  CLR};
        vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,  CLR};
        vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,  1'b0};

        rst = 1'b1; start_clear = 1'b0; start_load = 1'b0; start_read = 1'b0;
        base = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        adv(); adv();
        sample();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        adv();
        rst = 1'b0;

        // Start priority table: each job is aborted by reset one cycle after it starts.
        for (int i = 0; i < 8; i++) begin
            start_clear = vt[i].sc; start_load = vt[i].sl; start_read = vt[i].sr;
            base = 11'd100;
            sample();
            chk($sformatf("vec%0d_idle_busy", i), 32'(busy), 0);
            adv();
            start_clear = 1'b0; start_load = 1'b0; start_read = 1'b0;
            if (vt[i].e_we) exp_wr(100, 0);
            rst = 1'b1;
            sample();
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
            chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
            adv();
            rst = 1'b0;
            sample();
            chk($sformatf("vec%0d_abort_busy", i), 32'(busy), 0);
            chk($sformatf("vec%0d_abort_done", i), 32'(done), 0);
            adv();
        end
        chk("table_wq_drained", 32'(wq.size()), 0);

`ifdef R_MEM_CTRL_CLEAR_EN
        start_clear = 1'b1; base = '0;
        sample(); adv();
        start_clear = 1'b0;
        bad = 0;
        for (int k = 0; k < int'(PP); k++) begin
            exp_wr(k, 0);
            if (k == 10) begin start_load = 1'b1; start_read = 1'b1; end
            sample();
            if (!(mem_we === 1'b1 && busy === 1'b1 && done === 1'b0)) bad++;
            adv();
            start_load = 1'b0; start_read = 1'b0;
        end
        chk("clear_run_bad_cycles", 32'(bad), 0);
        sample();
        chk("clear_done", 32'(done), 1);
        chk("clear_done_busy", 32'(busy), 0);
        chk("clear_done_we", 32'(mem_we), 0);
        adv();
        sample();
        chk("clear_done_pulse", 32'(done), 0);
        adv();
        chk("clear_wq_drained", 32'(wq.size()), 0);
`endif

        // LOAD at 2040 with in_valid every other cycle; wraps past 2047.
        start_load = 1'b1; base = 11'd2040;
        sample(); adv();
        start_load = 1'b0;
        beat = 0; cyc = 0; bad = 0; dc0 = done_cnt;
        while (beat < int'(PP) && cyc < 4 * int'(PP)) begin
            in_valid = (cyc % 2 == 0);
            in_data  = in_valid ? RW'(beat) : 13'h1fff;
            if (cyc == 51) begin start_read = 1'b1; start_clear = 1'b1; end
            if (in_valid) exp_wr(2040 + beat, beat);
            sample();
            if (in_ready !== 1'b1) bad++;
            if (in_valid) beat++;
            adv();
            start_read = 1'b0; start_clear = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        chk("load_beats", 32'(beat), PP);
        chk("load_in_ready_bad", 32'(bad), 0);
        sample();
        chk("load_done", 32'(done), 1);
        chk("load_in_ready_after", 32'(in_ready), 0);
        chk("load_busy_after", 32'(busy), 0);
        adv();
        sample();
        chk("load_done_count", 32'(done_cnt - dc0), 1);
        adv();
        chk("load_wq_drained", 32'(wq.size()), 0);

        // READ back with out_ready high: first valid at t+2, then back-to-back.
        out_ready = 1'b1; start_read = 1'b1; base = 11'd2040;
        for (int i = 0; i < int'(PP); i++) rq.push_back(RW'(i));
        hs0 = rd_hs;
        sample(); adv();
        start_read = 1'b0;
        sample();
        chk("read_t1_valid", 32'(out_valid), 0);
        adv();
        sample();
        chk("read_t2_valid", 32'(out_valid), 1);
        adv();
        gap = 0; cyc = 0;
        while (rd_hs - hs0 < int'(PP) && cyc < int'(PP) + 20) begin
            sample();
            if (out_valid !== 1'b1) gap++;
            adv();
            cyc++;
        end
        chk("read1_count", 32'(rd_hs - hs0), PP);
        chk("read1_gaps", 32'(gap), 0);
        sample();
        chk("read1_done", 32'(done), 1);
        chk("read1_valid_after", 32'(out_valid), 0);
        chk("read1_busy_after", 32'(busy), 0);
        adv();
        chk("read1_rq_drained", 32'(rq.size()), 0);

        // READ with a 5-cycle stall mid-stream.
        start_read = 1'b1; base = 11'd2040;
        for (int i = 0; i < int'(PP); i++) rq.push_back(RW'(i));
        hs0 = rd_hs;
        sample(); adv();
        start_read = 1'b0;
        cyc = 0;
        while (rd_hs - hs0 < int'(PP) && cyc < int'(PP) + 40) begin
            out_ready = !(cyc >= 200 && cyc < 205);
            sample();
            if (!out_ready && rq.size() > 0) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(rq[0]));
            end
            adv();
            cyc++;
        end
        out_ready = 1'b1;
        chk("read2_count", 32'(rd_hs - hs0), PP);
        sample();
        chk("read2_done", 32'(done), 1);
        adv();
        chk("read2_rq_drained", 32'(rq.size()), 0);

        // Reset during LOAD at cnt=300, then a fresh LOAD must start at cnt=0.
        start_load = 1'b1; base = 11'd500;
        sample(); adv();
        start_load = 1'b0;
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'b1;
            in_data  = RW'(4096 + k);
            exp_wr(500 + k, 4096 + k);
            sample(); adv();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        dc0 = done_cnt;
        sample(); adv();
        rst = 1'b0;
        sample();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_out_data", 32'(out_data), 0);
        chk("abort_mem_we", 32'(mem_we), 0);
        chk("abort_mem_waddr", 32'(mem_waddr), 0);
        chk("abort_mem_wdata", 32'(mem_wdata), 0);
        adv();
        sample(); adv();
        chk("abort_no_done", 32'(done_cnt - dc0), 0);
        start_load = 1'b1; base = 11'd500;
        sample(); adv();
        start_load = 1'b0;
        for (int k = 0; k < int'(PP); k++) begin
            in_valid = 1'b1;
            in_data  = RW'(2000 + k);
            exp_wr(500 + k, 2000 + k);
            sample(); adv();
        end
        in_valid = 1'b0;
        sample();
        chk("reload_done", 32'(done), 1);
        adv();
        chk("reload_wq_drained", 32'(wq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
